// File: rtl/collision_checker.sv
// Per-frame bird/pipe/ground collision engine: snapshot positions, then a 4-step compare sequence.
// Optional macro COLLISION_CEILING_EN: a bird above the screen top (by < 0) also sets the bound bit.
module collision_checker #(
    parameter int BIRD_W   = 34,
    parameter int BIRD_H   = 24,
    parameter int PIPE_W   = 52,
    parameter int GAP_H    = 160,
    parameter int GROUND_Y = 400
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               new_frame,
    input  logic               enable,
    input  logic               clear,
    input  logic signed [15:0] bird_pos_x,
    input  logic signed [15:0] bird_pos_y,
    input  logic signed [15:0] pipe1_pos_x,
    input  logic signed [15:0] pipe1_pos_y,
    input  logic signed [15:0] pipe2_pos_x,
    input  logic signed [15:0] pipe2_pos_y,
    input  logic signed [15:0] pipe3_pos_x,
    input  logic signed [15:0] pipe3_pos_y,
    output logic               busy,
    output logic               done,
    output logic [3:0]         hit_mask,
    output logic               dead
);

    localparam logic signed [16:0] BIRD_W_S   = 17'(BIRD_W);
    localparam logic signed [16:0] BIRD_H_S   = 17'(BIRD_H);
    localparam logic signed [16:0] PIPE_W_S   = 17'(PIPE_W);
    localparam logic signed [16:0] GAP_H_S    = 17'(GAP_H);
    localparam logic signed [16:0] GROUND_Y_S = 17'(GROUND_Y);

    typedef enum logic [2:0] {IDLE, BOUND, P1, P2, P3} state_t;

    state_t             state;
    logic signed [15:0] bx, by, p1x, p1y, p2x, p2y, p3x, p3y;
    logic [3:0]         work;

    logic signed [15:0] cur_px, cur_py;
    logic signed [16:0] bx_e, by_e, px_e, py_e;
    logic               x_overlap_c, in_gap_c, pipe_hit_c, bound_hit_c;
    logic [3:0]         final_mask_c;

    // Select the pipe under test for the current compare state.
    always_comb begin
        cur_px = p1x;
        cur_py = p1y;
        case (state)
            P2:      begin cur_px = p2x; cur_py = p2y; end
            P3:      begin cur_px = p3x; cur_py = p3y; end
            default: ;
        endcase
    end

    assign bx_e = {bx[15], bx};
    assign by_e = {by[15], by};
    assign px_e = {cur_px[15], cur_px};
    assign py_e = {cur_py[15], cur_py};

    assign x_overlap_c = (bx_e < px_e + PIPE_W_S) && (px_e < bx_e + BIRD_W_S);
    assign in_gap_c    = (by_e >= py_e) && (by_e + BIRD_H_S <= py_e + GAP_H_S);
    assign pipe_hit_c  = x_overlap_c && !in_gap_c;

`ifdef COLLISION_CEILING_EN
    assign bound_hit_c = (by_e + BIRD_H_S > GROUND_Y_S) || (by_e < 17'sd0);
`else
    assign bound_hit_c = (by_e + BIRD_H_S > GROUND_Y_S);
`endif

    // P3 result is folded in directly so the published mask includes it.
    assign final_mask_c = {work[3], pipe_hit_c, work[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            hit_mask <= 4'b0000;
            dead     <= 1'b0;
            work     <= 4'b0000;
            bx       <= 16'sd0;
            by       <= 16'sd0;
            p1x      <= 16'sd0;
            p1y      <= 16'sd0;
            p2x      <= 16'sd0;
            p2y      <= 16'sd0;
            p3x      <= 16'sd0;
            p3y      <= 16'sd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (new_frame && enable) begin
                        bx    <= bird_pos_x;
                        by    <= bird_pos_y;
                        p1x   <= pipe1_pos_x;
                        p1y   <= pipe1_pos_y;
                        p2x   <= pipe2_pos_x;
                        p2y   <= pipe2_pos_y;
                        p3x   <= pipe3_pos_x;
                        p3y   <= pipe3_pos_y;
                        work  <= 4'b0000;
                        busy  <= 1'b1;
                        state <= BOUND;
                    end
                end
                default: begin
                    if (!enable) begin
                        // Game left FLY mid-check: drop the partial result silently.
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        case (state)
                            BOUND: begin
                                work[3] <= bound_hit_c;
                                state   <= P1;
                            end
                            P1: begin
                                work[0] <= pipe_hit_c;
                                state   <= P2;
                            end
                            P2: begin
                                work[1] <= pipe_hit_c;
                                state   <= P3;
                            end
                            P3: begin
                                work     <= final_mask_c;
                                hit_mask <= final_mask_c;
                                done     <= 1'b1;
                                busy     <= 1'b0;
                                dead     <= dead | (|final_mask_c);
                                state    <= IDLE;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            endcase
            if (clear) begin
                dead <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_collision_checker.sv
// Directed self-checking bench for collision_checker with hand-computed expected masks.
`timescale 1ns/1ps
module tb_collision_checker;

    logic               clk;
    logic               rst;
    logic               new_frame;
    logic               enable;
    logic               clear;
    logic signed [15:0] bird_pos_x, bird_pos_y;
    logic signed [15:0] pipe1_pos_x, pipe1_pos_y;
    logic signed [15:0] pipe2_pos_x, pipe2_pos_y;
    logic signed [15:0] pipe3_pos_x, pipe3_pos_y;
    logic               busy;
    logic               done;
    logic [3:0]         hit_mask;
    logic               dead;

    int n_cmp = 0;
    int n_err = 0;

    collision_checker dut (
        .clk         (clk),
        .rst         (rst),
        .new_frame   (new_frame),
        .enable      (enable),
        .clear       (clear),
        .bird_pos_x  (bird_pos_x),
        .bird_pos_y  (bird_pos_y),
        .pipe1_pos_x (pipe1_pos_x),
        .pipe1_pos_y (pipe1_pos_y),
        .pipe2_pos_x (pipe2_pos_x),
        .pipe2_pos_y (pipe2_pos_y),
        .pipe3_pos_x (pipe3_pos_x),
        .pipe3_pos_y (pipe3_pos_y),
        .busy        (busy),
        .done        (done),
        .hit_mask    (hit_mask),
        .dead        (dead)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full check: strobe, 4 busy cycles, result cycle, then idle cycle.
    task automatic frame(input string tag, input logic [3:0] exp_mask, input logic exp_dead,
                         input bit clr_p3, input bit nf_mid);
        @(negedge clk);
        new_frame = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
        chk({tag, ".busy1"}, busy, 1);
        chk({tag, ".done1"}, done, 0);
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            new_frame = (nf_mid && i == 2);
            clear     = (clr_p3 && i == 4);
            chk($sformatf("%s.busy%0d", tag, i), busy, 1);
        end
        @(negedge clk);
        new_frame = 1'b0;
        clear     = 1'b0;
        chk({tag, ".done"}, done, 1);
        chk({tag, ".busy_off"}, busy, 0);
        chk({tag, ".mask"}, hit_mask, exp_mask);
        chk({tag, ".dead"}, dead, exp_dead);
        @(negedge clk);
        chk({tag, ".done_pulse"}, done, 0);
        chk({tag, ".idle"}, busy, 0);
    endtask

    task automatic pulse_clear(input string tag);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk(tag, dead, 0);
    endtask

    task automatic set_base();
        bird_pos_x  = 16'sd128;
        bird_pos_y  = 16'sd100;
        pipe1_pos_x = 16'sd680;
        pipe1_pos_y = -16'sd50;
        pipe2_pos_x = 16'sd500;
        pipe2_pos_y = 16'sd150;
        pipe3_pos_x = 16'sd450;
        pipe3_pos_y = 16'sd350;
    endtask

    logic [3:0] ceil_mask;

    initial begin
        rst       = 1'b1;
        new_frame = 1'b0;
        enable    = 1'b1;
        clear     = 1'b0;
        set_base();
`ifdef COLLISION_CEILING_EN
        ceil_mask = 4'b1000;
`else
        ceil_mask = 4'b0000;
`endif
        repeat (3) @(negedge clk);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.mask", hit_mask, 0);
        chk("rst.dead", dead, 0);
        rst = 1'b0;

        // Open air, with a stray strobe mid-check that must be ignored.
        frame("open", 4'b0000, 1'b0, 1'b0, 1'b1);

        // Gap pass, then pipe hit, then sticky dead.
        pipe1_pos_x = 16'sd140;
        pipe1_pos_y = 16'sd50;
        frame("gap", 4'b0000, 1'b0, 1'b0, 1'b0);
        pipe1_pos_y = 16'sd110;
        frame("hit1", 4'b0001, 1'b1, 1'b0, 1'b0);
        pipe1_pos_y = 16'sd50;
        frame("sticky", 4'b0000, 1'b1, 1'b0, 1'b0);
        pulse_clear("clear1");
        set_base();

        // Ground edge.
        bird_pos_y = 16'sd376;
        frame("gnd376", 4'b0000, 1'b0, 1'b0, 1'b0);
        bird_pos_y = 16'sd377;
        frame("gnd377", 4'b1000, 1'b1, 1'b0, 1'b0);
        pulse_clear("clear2");
        set_base();

        // X edge on pipe2.
        pipe2_pos_y = 16'sd300;
        pipe2_pos_x = 16'sd162;
        frame("x162", 4'b0000, 1'b0, 1'b0, 1'b0);
        pipe2_pos_x = 16'sd161;
        frame("x161", 4'b0010, 1'b1, 1'b0, 1'b0);

        // Reset mid-check returns everything to reset values.
        @(negedge clk);
        new_frame = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst.busy", busy, 0);
        chk("midrst.mask", hit_mask, 0);
        chk("midrst.dead", dead, 0);
        repeat (4) @(negedge clk);
        chk("midrst.nodone", done, 0);
        set_base();

        // Ceiling: outcome depends on build option.
        bird_pos_y = -16'sd5;
        frame("ceil", ceil_mask, |ceil_mask, 1'b0, 1'b0);
        pulse_clear("clear3");
        set_base();

        // Abort: enable drops two cycles after the strobe on a hitting frame.
        bird_pos_y = 16'sd377;
        @(negedge clk);
        new_frame = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
        chk("abort.busy", busy, 1);
        @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("abort.nodone%0d", i), done, 0);
        end
        chk("abort.busy_off", busy, 0);
        chk("abort.mask", hit_mask, ceil_mask);
        chk("abort.dead", dead, 0);

        // Strobe with enable low is ignored.
        @(negedge clk);
        new_frame = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
        chk("disabled.busy", busy, 0);
        repeat (4) @(negedge clk);
        chk("disabled.done", done, 0);
        enable = 1'b1;

        // Clear coinciding with the completing edge wins over the hit.
        frame("prec", 4'b1000, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/collision_checker.md
# collision_checker

Per-frame collision engine for the Flappy Bird game datapath. It consumes the bird and pipe positions that the game logic publishes each frame and returns a `dead` indication through a small sequential compare state machine. It drives the game FSM's `dead` input and sits between the game logic and the renderer on the same frame strobe.

## Interface
- `BIRD_W`, 34: bird bounding-box width, pixels
- `BIRD_H`, 24: bird bounding-box height, pixels
- `PIPE_W`, 52: pipe column width, pixels
- `GAP_H`, 160: vertical opening height of each pipe, pixels
- `GROUND_Y`, 400: screen Y of the ground line; bird bottom edge must not exceed it
- `clk`  in  1  system clock
- `rst`  in  1  synchronous reset, active-high
- `new_frame`  in  1  one-cycle frame strobe; starts a check
- `enable`  in  1  high while the game is in FLY; gates checks
- `clear`  in  1  one-cycle pulse; clears sticky `dead`
- `bird_pos_x`, `bird_pos_y`  in  16 signed each  bird box top-left corner
- `pipe1_pos_x` … `pipe3_pos_x`  in  16 signed each  pipe left edge
- `pipe1_pos_y` … `pipe3_pos_y`  in  16 signed each  top edge of the pipe gap
- `busy`  out  1  check in progress
- `done`  out  1  one-cycle pulse; results valid
- `hit_mask`  out  4  {bound, pipe3, pipe2, pipe1} result of last completed check
- `dead`  out  1  sticky collision flag

## Operation
- FSM states: IDLE, BOUND, P1, P2, P3. Each non-IDLE state lasts exactly one cycle.
- IDLE, `new_frame & enable`: snapshot all 8 position inputs into internal registers, clear the working mask, go to BOUND. All later compares use the snapshot only.
- BOUND: set working bit 3 if `by + BIRD_H > GROUND_Y`. Go to P1.
- Pn: set working bit n-1 if x-overlap and not in-gap. Pn goes to Pn+1. P3 goes to IDLE.
  - x-overlap: `bx < px + PIPE_W` and `px < bx + BIRD_W`.
  - in-gap: `by >= py` and `by + BIRD_H <= py + GAP_H`.
- On the P3→IDLE transition:
  - `hit_mask` <= working mask, including the P3 bit.
  - `done` <= 1.
  - `dead` <= `dead | (|mask)`.
- Arithmetic: all sums and compares use 17-bit signed values; sign-extend the operands first. Negative positions are legal.
- `dead` is sticky. It clears only on `clear` or `rst`.
- Boundary conditions:
  - `new_frame` outside IDLE is ignored. No queuing.
  - `new_frame` with `enable` low is ignored.
  - `enable` falls during BOUND..P3: abort to IDLE. No `done`; `hit_mask` and `dead` are unchanged.
  - `clear` in the same cycle as the P3→IDLE transition: `clear` wins for `dead` (`dead` = 0). `hit_mask` still updates and `done` still pulses.
  - `rst` mid-check: immediate return to IDLE; all outputs take their reset values.

## Timing
- Reset values: `busy` = 0, `done` = 0, `hit_mask` = 4'b0000, `dead` = 0, state = IDLE.
- `new_frame` is sampled at cycle T. `busy` is high in cycles T+1..T+4. `done`, `hit_mask` and the updated `dead` appear in cycle T+5.
- `done` is high for exactly one cycle. `busy` and `done` are never high together.
- The FSM is in IDLE in cycle T+5, so a `new_frame` in that cycle is accepted.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `COLLISION_CEILING_EN` defined: BOUND also sets bit 3 when `by < 0` (bird above the screen top is fatal).
- `COLLISION_CEILING_EN` undefined: only the ground test drives bit 3. Negative `by` is never a hit by itself.

## Test plan
- Open air:
  - Stimulus: bird (128,100); pipes x = 680/500/450, y = −50/150/350; `enable` = 1; `new_frame` pulse.
  - Response: `busy` high 4 cycles; `done` 5 cycles after the strobe; `hit_mask` = 0000; `dead` = 0.
- Gap pass and pipe hit:
  - Stimulus: bird (128,100), pipe1 (140,50).
  - Response: `hit_mask` = 0000.
  - Then: pipe1 y = 110.
  - Response: `hit_mask` = 0001, `dead` = 1. `dead` stays 1 on the next clean frame until a `clear` pulse sets it to 0.
- Ground edge:
  - Stimulus: bird y = 376 (bottom = 400).
  - Response: `hit_mask` = 0000.
  - Stimulus: bird y = 377.
  - Response: `hit_mask` = 1000.
- X edge:
  - Stimulus: bird (128,100), pipe2 y = 300, pipe2 x = 162.
  - Response: no hit.
  - Stimulus: pipe2 x = 161.
  - Response: `hit_mask` = 0010.
- Ceiling:
  - Stimulus: bird y = −5, no pipe overlap.
  - Response with `COLLISION_CEILING_EN`: `hit_mask` = 1000, `dead` = 1.
  - Response without it: `hit_mask` = 0000.
- Abort and precedence:
  - Stimulus: drop `enable` 2 cycles after `new_frame` with a hitting configuration.
  - Response: no `done`, `dead` stays 0.
  - Stimulus: assert `clear` in the `done` cycle of a hitting check.
  - Response: `hit_mask` updated, `dead` = 0.
